// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing a byte-wide register bank. SCLK, SS_n and MOSI
// are oversampled in the Clk domain; nothing is clocked by SCLK.
module spi_reg_responder #(
  parameter int unsigned NREGS     = 16,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       SCLK,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_OE,
  input  logic [7:0] STATUS,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_DATA,
  output logic       WR_STROBE,
  output logic [4:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       BUSY
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // [0],[1] form the synchronizer; [2] is the edge-detect history flop
  logic [2:0] sclk_sync_q;
  logic [2:0] ss_sync_q;
  logic [1:0] mosi_sync_q;

  logic [1:0] state_q,     state_d;
  logic [7:0] tx_q,        tx_d;
  logic [7:0] rx_q,        rx_d;
  logic [7:0] next_tx_q,   next_tx_d;
  logic [2:0] bitcnt_q,    bitcnt_d;
  logic [4:0] addr_q,      addr_d;
  logic       dir_q,       dir_d;
  logic       armed_q,     armed_d;
  logic       miso_oe_q,   miso_oe_d;
  logic       busy_q,      busy_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [4:0] wr_addr_q,   wr_addr_d;
  logic [7:0] wr_data_q,   wr_data_d;
  logic [7:0] regs_q [NREGS];
  logic [7:0] regs_d [NREGS];

  logic       sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [7:0] rx_byte;

  function automatic logic is_impl(input logic [4:0] a);
    return 32'(a) < NREGS;
  endfunction

  function automatic logic [7:0] reg_rd(input logic [4:0] a);
    logic [7:0] v;
    v = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (a == 5'(i)) v = regs_q[i];
    end
    return v;
  endfunction

  // Synchronizers reset low so a select already asserted at reset never
  // produces a falling edge; arming needs a genuine high on SS_n first.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
      ss_sync_q   <= {ss_sync_q[1:0], SS_n};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];
  assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
  assign rx_byte   = {rx_q[6:0], mosi_sync_q[1]};

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    next_tx_d   = next_tx_q;
    bitcnt_d    = bitcnt_q;
    addr_d      = addr_q;
    dir_d       = dir_q;
    armed_d     = armed_q | ss_sync_q[1];
    miso_oe_d   = miso_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;

    case (state_q)
      ST_IDLE: begin
        if (armed_q && ss_fall) begin
          state_d   = ST_CMD;
          tx_d      = STATUS;
          miso_oe_d = 1'b1;
          busy_d    = 1'b1;
          bitcnt_d  = '0;
        end
      end
      ST_CMD, ST_DATA: begin
        if (ss_rise) begin
          state_d   = ST_IDLE;
          tx_d      = '0;
          miso_oe_d = 1'b0;
          busy_d    = 1'b0;
        end else if (sclk_rise) begin
          rx_d     = rx_byte;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            if (state_q == ST_CMD) begin
              state_d = ST_DATA;
              dir_d   = rx_byte[1];
              if (rx_byte[1]) begin
                addr_d    = rx_byte[7:3];
                next_tx_d = '0;
              end else begin
                addr_d    = rx_byte[7:3] + 5'd1;
                next_tx_d = reg_rd(rx_byte[7:3]);
              end
            end else if (dir_q) begin
              if (is_impl(addr_q)) begin
                for (int unsigned i = 0; i < NREGS; i++) begin
                  if (addr_q == 5'(i)) regs_d[i] = rx_byte;
                end
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q;
                wr_data_d   = rx_byte;
              end
              next_tx_d = '0;
              addr_d    = addr_q + 5'd1;
            end else begin
              next_tx_d = reg_rd(addr_q);
              addr_d    = addr_q + 5'd1;
            end
          end
        end else if (sclk_fall) begin
          // bit counter at zero means a byte boundary: present the next byte
          tx_d = (bitcnt_q == 3'd0) ? next_tx_q : {tx_q[6:0], 1'b0};
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      next_tx_q   <= '0;
      bitcnt_q    <= '0;
      addr_q      <= '0;
      dir_q       <= 1'b0;
      armed_q     <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      next_tx_q   <= next_tx_d;
      bitcnt_q    <= bitcnt_d;
      addr_q      <= addr_d;
      dir_q       <= dir_d;
      armed_q     <= armed_d;
      miso_oe_q   <= miso_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  always_comb RD_DATA = reg_rd(RD_ADDR);

  assign MISO      = miso_oe_q & tx_q[7];
  assign MISO_OE   = miso_oe_q;
  assign BUSY      = busy_q;
  assign WR_STROBE = wr_strobe_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;

endmodule
